// File: rtl/bkg_painter.sv
// rtl/bkg_painter.sv - rectangle fill engine driving the background RAM write port
// Clips a requested rectangle to the screen and writes one palette index per pixel.
module bkg_painter #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17,
  parameter int INDEX_W  = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [8:0]         req_x,
  input  logic [7:0]         req_y,
  input  logic [8:0]         req_w,
  input  logic [7:0]         req_h,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               paint_en,
  output logic [ADDR_W-1:0]  write_address,
  output logic [INDEX_W-1:0] data_In,
  output logic               we,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  localparam logic [9:0]        SCREEN_W10 = 10'(SCREEN_W);
  localparam logic [9:0]        SCREEN_H10 = 10'(SCREEN_H);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(SCREEN_W);

  state_t            state, state_next;
  logic [8:0]        x_q, w_q;
  logic [7:0]        y_q, h_q;
  logic [9:0]        x_end, y_end;
  logic [8:0]        col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] row_base;

  logic [9:0]        x_sum, y_sum;
  logic              empty, col_more, row_more;
  logic [ADDR_W-1:0] base_calc;

  // Sums are one bit wider than the operands so large requests clip instead of wrapping.
  assign x_sum     = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum     = {2'b0, y_q} + {2'b0, h_q};
  assign empty     = (w_q == 9'd0) || (h_q == 8'd0) ||
                     ({1'b0, x_q} >= SCREEN_W10) || ({2'b0, y_q} >= SCREEN_H10);
  assign base_calc = ADDR_W'(y_q) * STRIDE + ADDR_W'(x_q);
  assign col_more  = ({1'b0, col} + 10'd1) < x_end;
  assign row_more  = ({2'b0, row} + 10'd1) < y_end;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = CALC;
      end
      CALC:  state_next = empty ? DONE : WRITE;
      WRITE: begin
        we = paint_en;
        if (paint_en && !col_more && !row_more) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      x_end         <= '0;
      y_end         <= '0;
      col           <= '0;
      row           <= '0;
      row_base      <= '0;
      write_address <= '0;
      data_In       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          x_q     <= req_x;
          y_q     <= req_y;
          w_q     <= req_w;
          h_q     <= req_h;
          data_In <= req_index;
        end
        CALC: if (!empty) begin
          x_end         <= (x_sum > SCREEN_W10) ? SCREEN_W10 : x_sum;
          y_end         <= (y_sum > SCREEN_H10) ? SCREEN_H10 : y_sum;
          col           <= x_q;
          row           <= y_q;
          row_base      <= base_calc;
          write_address <= base_calc;
        end
        // Counters only advance on cycles where the write actually happened.
        WRITE: if (paint_en) begin
          if (col_more) begin
            col           <= col + 9'd1;
            write_address <= write_address + ADDR_W'(1);
          end else if (row_more) begin
            row           <= row + 8'd1;
            row_base      <= row_base + STRIDE;
            write_address <= row_base + STRIDE;
            col           <= x_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
